// File: rtl/io_uart_bank_if.sv
// MMU I/O port bundle: 8-bit byte offset, 32-bit write data, combinational read data.
interface io_uart_bank_if;
  logic [7:0]  io_addr;
  logic        io_en;
  logic        io_we;
  logic [31:0] io_data_write;
  logic [31:0] io_data_read;

  modport master (output io_addr, io_en, io_we, io_data_write, input io_data_read);
  modport slave  (input io_addr, io_en, io_we, io_data_write, output io_data_read);
endinterface

// File: rtl/io_uart_bank.sv
// I/O responder: LED register, free-running cycle counter and a TX FIFO
// draining into an 8N1 UART transmitter. Reads are combinational off
// pre-edge state; writes and FIFO side effects commit on the clock edge.
module io_uart_bank #(
  parameter int CLKS_PER_BIT   = 104,
  parameter int FIFO_DEPTH     = 8,
  parameter int FIFO_DEPTH_LOG = 3
) (
  input  logic                 clk,
  input  logic                 resetb,
  io_uart_bank_if.slave        bus,
  output logic [7:0]           leds,
  output logic                 uart_tx
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0]         BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_DEPTH_LOG:0]   FULL_CNT  = (FIFO_DEPTH_LOG + 1)'(FIFO_DEPTH);

  localparam logic [5:0] OFF_LED    = 6'd0;
  localparam logic [5:0] OFF_TXDATA = 6'd1;
  localparam logic [5:0] OFF_STATUS = 6'd2;
  localparam logic [5:0] OFF_CYCLE  = 6'd3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  tx_state_e                 state;
  logic [BAUD_W-1:0]         baud_cnt;
  logic [2:0]                bit_idx;
  logic [7:0]                shreg;

  logic [7:0]                mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG-1:0] rd_ptr, wr_ptr;
  logic [FIFO_DEPTH_LOG:0]   count;
  logic                      overflow;
  logic [31:0]               cycle;

  logic [5:0]  off;
  logic        wr_en, push_req, push, pop, full, empty, ovf_clr;
  logic [31:0] status;
  logic        unused_bits;

  assign off      = bus.io_addr[7:2];
  assign wr_en    = bus.io_en & bus.io_we;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push_req = wr_en & (off == OFF_TXDATA);
  // A full FIFO drops the push even if a pop frees a slot on the same edge.
  assign push     = push_req & ~full;
  assign pop      = (state == IDLE) & ~empty;
  assign ovf_clr  = wr_en & (off == OFF_STATUS) & bus.io_data_write[3];
  assign unused_bits = ^{bus.io_addr[1:0], bus.io_data_write[31:8]};

  // Status word assembled from live FIFO/FSM state.
  always_comb begin
    status = '0;
    status[0] = full;
    status[1] = empty;
    status[2] = (state != IDLE);
    status[3] = overflow;
    status[8 +: FIFO_DEPTH_LOG+1] = count;
  end

  // Combinational read mux; zero when no access is presented.
  always_comb begin
    bus.io_data_read = '0;
    if (bus.io_en) begin
      case (off)
        OFF_LED:    bus.io_data_read = {24'h0, leds};
        OFF_STATUS: bus.io_data_read = status;
        OFF_CYCLE:  bus.io_data_read = cycle;
        default:    bus.io_data_read = '0;
      endcase
    end
  end

  // LED register, cycle counter and sticky overflow (set beats clear).
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      leds     <= '0;
      cycle    <= '0;
      overflow <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;
      if (wr_en && off == OFF_LED) leds <= bus.io_data_write[7:0];
      if (push_req && full)        overflow <= 1'b1;
      else if (ovf_clr)            overflow <= 1'b0;
    end
  end

  // FIFO storage; contents are don't-care until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.io_data_write[7:0];
  end

  // FIFO pointers and occupancy; simultaneous push+pop leaves count unchanged.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // 8N1 transmitter: start, 8 data bits LSB first, stop; uart_tx registered.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          uart_tx  <= 1'b1;
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (pop) begin
            shreg   <= mem[rd_ptr];
            state   <= START;
            uart_tx <= 1'b0;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_tx  <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              uart_tx <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          uart_tx <= 1'b1;
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_bank.sv
// Bench for io_uart_bank: directed MMU accesses, a cycle-level reference
// model compared every cycle, a serial receiver, and literal expectations.
module tb_io_uart_bank;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int DLOG  = 3;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  logic [7:0] leds;
  logic uart_tx;

  always #5 clk = ~clk;

  io_uart_bank_if bus();

  io_uart_bank #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .FIFO_DEPTH_LOG(DLOG)) dut (
    .clk(clk), .resetb(resetb), .bus(bus), .leds(leds), .uart_tx(uart_tx)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, a, e, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame popped at edge p keeps the transmitter busy after edges p..p+10*CPB-1.
  logic [7:0]  mq[$];
  logic        m_ovf;
  logic [7:0]  m_leds;
  logic [31:0] m_cyc;
  logic        m_act;
  logic [7:0]  m_cur;
  int          m_n;
  int          m_p;

  function automatic bit busy_at(input int e);
    return m_act && (e >= m_p) && (e - m_p < 10 * CPB);
  endfunction

  function automatic logic exp_tx();
    int k;
    if (!busy_at(m_n)) return 1'b1;
    k = (m_n - m_p) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0] = (mq.size() == DEPTH);
    s[1] = (mq.size() == 0);
    s[2] = busy_at(m_n);
    s[3] = m_ovf;
    s[8 +: DLOG+1] = (DLOG+1)'(mq.size());
    return s;
  endfunction

  function automatic logic [31:0] exp_rd();
    if (!bus.io_en) return 32'h0;
    case (bus.io_addr[7:2])
      6'd0:    return {24'h0, m_leds};
      6'd2:    return exp_status();
      6'd3:    return m_cyc;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    m_ovf = 0; m_leds = 0; m_cyc = 0; m_act = 0; m_cur = 0; m_n = 0; m_p = 0;
    forever begin
      @(posedge clk or negedge resetb);
      if (!resetb) begin
        mq.delete(); m_ovf = 0; m_leds = 0; m_cyc = 0; m_act = 0; m_n = 0; m_p = 0;
      end else begin
        bit pre_busy, was_full, wr, push_req;
        pre_busy = busy_at(m_n);
        m_n++;
        m_cyc++;
        was_full = (mq.size() == DEPTH);
        wr = bus.io_en && bus.io_we;
        push_req = wr && bus.io_addr[7:2] == 6'd1;
        if (wr && bus.io_addr[7:2] == 6'd0) m_leds = bus.io_data_write[7:0];
        if (push_req && was_full) m_ovf = 1;
        else if (wr && bus.io_addr[7:2] == 6'd2 && bus.io_data_write[3]) m_ovf = 0;
        if (!pre_busy && mq.size() > 0) begin
          m_cur = mq.pop_front();
          m_act = 1;
          m_p = m_n;
        end
        if (push_req && !was_full) mq.push_back(bus.io_data_write[7:0]);
      end
    end
  end

  // Every-cycle compare, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("tx", {31'h0, uart_tx}, {31'h0, exp_tx()});
    chk("leds", {24'h0, leds}, {24'h0, m_leds});
    chk("rdata", bus.io_data_read, exp_rd());
  end

  // ---------------- serial receiver ----------------
  logic [7:0] rxq[$];
  initial forever begin
    @(negedge clk);
    if (resetb && uart_tx === 1'b0) begin
      logic [7:0] b;
      repeat (CPB/2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      rxq.push_back(b);
    end
  end

  // ---------------- bus tasks ----------------
  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.io_addr = a; bus.io_data_write = d; bus.io_we = 1; bus.io_en = 1;
    @(posedge clk); #1;
    bus.io_en = 0; bus.io_we = 0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    bus.io_addr = a; bus.io_we = 0; bus.io_en = 1;
    #3 d = bus.io_data_read;
    @(posedge clk); #1;
    bus.io_en = 0;
  endtask

  // ---------------- directed stimulus ----------------
  logic [9:0]  frm;
  logic        s[41];
  logic [31:0] v, v2;

  initial begin
    bus.io_addr = 0; bus.io_en = 0; bus.io_we = 0; bus.io_data_write = 0;
    frm = 10'b1101001010;  // stop, A5 MSB..LSB, start
    repeat (2) @(posedge clk);
    #1 resetb = 1;

    // reset state and cycle counter start
    idle(10);
    rd(8'h0C, v);
    checks++;
    if (!(v >= 32'd9 && v <= 32'd11)) begin
      errs++;
      $display("FAIL cycle_after_reset: got %0d expected 10+-1", v);
    end
    rd(8'h08, v); chk("status_reset", v, 32'h2);
    chk("tx_reset", {31'h0, uart_tx}, 32'h1);

    // LED and unmapped offsets
    wr(8'h00, 32'h000000A5);
    chk("leds_write", {24'h0, leds}, 32'hA5);
    rd(8'h00, v); chk("led_read", v, 32'hA5);
    rd(8'h40, v); chk("unmapped_read", v, 32'h0);
    wr(8'h40, 32'hFFFFFFFF);
    chk("leds_after_unmapped", {24'h0, leds}, 32'hA5);
    rd(8'h08, v); chk("status_after_unmapped", v, 32'h2);
    rd(8'h04, v); chk("txdata_read", v, 32'h0);

    // cycle delta
    rd(8'h0C, v); idle(5); rd(8'h0C, v2);
    chk("cycle_delta", v2 - v, 32'd6);

    // single byte frame
    wr(8'h04, 32'h000000A5);
    for (int i = 0; i < 41; i++) begin
      if (i == 20) begin bus.io_addr = 8'h08; bus.io_we = 0; bus.io_en = 1; end
      #3 s[i] = uart_tx;
      if (i == 20) chk("busy_mid_frame", {31'h0, bus.io_data_read[2]}, 32'h1);
      @(posedge clk); #1;
      bus.io_en = 0;
    end
    chk("tx_before_pop", {31'h0, s[0]}, 32'h1);
    for (int j = 0; j < 40; j++) chk("frame_bit", {31'h0, s[j+1]}, {31'h0, frm[j/CPB]});
    rd(8'h08, v); chk("status_after_frame", v, 32'h2);

    // overflow
    rxq.delete();
    for (int k = 1; k <= 10; k++) wr(8'h04, 32'(k));
    rd(8'h08, v); chk("status_overflow", v, 32'h0000080D);
    wr(8'h08, 32'h8);
    rd(8'h08, v); chk("status_ovf_clear", v, 32'h00000805);
    idle(420);
    chk("rx_count", 32'(rxq.size()), 32'd9);
    for (int k = 0; k < 9 && k < rxq.size(); k++) chk("rx_byte", {24'h0, rxq[k]}, 32'(k + 1));
    rd(8'h08, v); chk("status_drained", v, 32'h2);

    // reset mid-frame
    wr(8'h04, 32'h55); wr(8'h04, 32'h11); wr(8'h04, 32'h22); wr(8'h04, 32'h33);
    idle(6);
    #2 resetb = 0;
    #1;
    chk("tx_async_reset", {31'h0, uart_tx}, 32'h1);
    chk("leds_async_reset", {24'h0, leds}, 32'h0);
    repeat (2) @(posedge clk);
    #1 resetb = 1;
    idle(60);
    rd(8'h08, v); chk("status_after_reset", v, 32'h2);
    chk("tx_after_reset", {31'h0, uart_tx}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
